// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch slice:
//               sequencer state encoding, default widths, opcode field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Default datapath widths: 16-entry, 16-bit program ROM.
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_INST_W = 16;

  // Sequencer state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Opcode field lives in inst[15:12].
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [3:0] OPC_NOP  = 4'b0000;
  localparam logic [3:0] OPC_LOAD = 4'b0001;
  localparam logic [3:0] OPC_ADD  = 4'b0010;
  localparam logic [3:0] OPC_BR   = 4'b1100;
  localparam logic [3:0] OPC_MOV  = 4'b1110;
  localparam logic [3:0] OPC_OUT  = 4'b1111;

  // Extract the opcode field from a 16-bit instruction word.
  function automatic logic [3:0] opcode_of(input logic [DEF_INST_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if
// Description : ROM, decode handshake and branch-redirect signals between the
//               fetch sequencer (master) and its ROM/decode/execute neighbours
//               (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W
) ();

  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_data;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;

  modport master (
    output rom_addr,
    input  rom_data,
    output inst,
    output inst_pc,
    output inst_valid,
    input  inst_ready,
    input  br_valid,
    input  br_target
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  inst,
    input  inst_pc,
    input  inst_valid,
    output inst_ready,
    output br_valid,
    output br_target
  );

endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : pc_counter
// Description : Program counter with load (start / branch) and increment.
//               Increment wraps modulo 2^ADDR_W; at_last flags the final
//               address so the sequencer can decide whether to halt.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_counter #(
  parameter int                ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic              at_last
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: a load beats an increment; the add wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc      = pc_q;
  assign at_last = &pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction-fetch controller. Drives the ROM address from the
//               PC, captures ROM data into a one-entry instruction register
//               and presents it to decode over valid/ready. Supports start,
//               stop, branch redirect (1-bubble flush) and halt on PC wrap.
//               Optional macro FETCH_STEP_EN adds single-step ports
//               step_mode/step gating each fetch on a (1-deep buffered) pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter int                INST_W       = DEF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter bit                HALT_ON_WRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop_req,
`ifdef FETCH_STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  fetch_if.master    bus,
  output logic       busy,
  output logic       halted,
  output logic [7:0] fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic [7:0]        count_q, count_d;

  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc;
  logic              pc_at_last;
  logic              slot_free;
  logic              step_ok;
  logic              fetch_fire;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc),
    .at_last  (pc_at_last)
  );

  assign slot_free = !inst_valid_q || bus.inst_ready;

`ifdef FETCH_STEP_EN
  logic step_pend_q, step_pend_d;

  // Fetch permission: free-running unless step_mode, then one per step pulse.
  always_comb begin
    step_ok = !step_mode || step || step_pend_q;
  end

  // Remember one step pulse that could not be used yet; forget it outside RUN.
  always_comb begin
    step_pend_d = step_pend_q;
    if (state_q != RUN) begin
      step_pend_d = 1'b0;
    end else if (fetch_fire && step_mode) begin
      // The older pending pulse is used first; a new one then stays pending.
      step_pend_d = step_pend_q && step;
    end else if (step) begin
      step_pend_d = 1'b1;
    end
  end

  // Pending-step register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_pend_q <= 1'b0;
    end else begin
      step_pend_q <= step_pend_d;
    end
  end
`else
  assign step_ok = 1'b1;
`endif

  // FSM next state, instruction register and fetch counter updates.
  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    count_d      = count_q;
    pc_load      = 1'b0;
    pc_load_val  = RESET_PC;
    pc_inc       = 1'b0;
    fetch_fire   = 1'b0;

    // Decode taking the held instruction empties the slot unless refilled.
    if (inst_valid_q && bus.inst_ready) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      IDLE, HALTED: begin
        // start beats stop_req; stop is meaningless here anyway.
        if (start) begin
          state_d     = RUN;
          pc_load     = 1'b1;
          pc_load_val = RESET_PC;
          count_d     = 8'd0;
        end
      end

      RUN: begin
        if (bus.br_valid) begin
          // Redirect wins over fetch and stall; flush the held instruction.
          pc_load      = 1'b1;
          pc_load_val  = bus.br_target;
          inst_valid_d = 1'b0;
          if (stop_req) begin
            state_d = HALTED;
          end
        end else if (stop_req) begin
          // Held instruction is left for decode to drain.
          state_d = HALTED;
        end else if (slot_free && step_ok) begin
          fetch_fire   = 1'b1;
          inst_d       = bus.rom_data;
          inst_pc_d    = pc;
          inst_valid_d = 1'b1;
          pc_inc       = 1'b1;
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
          if (HALT_ON_WRAP && pc_at_last) begin
            state_d = HALTED;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, instruction register and counter flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      count_q      <= count_d;
    end
  end

  assign bus.rom_addr   = pc;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign busy           = (state_q == RUN);
  assign halted         = (state_q == HALTED);
  assign fetch_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. Expected fetch
//               addresses are queued as stimulus is applied and compared
//               against each instruction decode accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int ADDR_W = 4;
  localparam int INST_W = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop_req;
  logic       busy;
  logic       halted;
  logic [7:0] fetch_count;
`ifdef FETCH_STEP_EN
  logic       step_mode = 1'b0;
  logic       step      = 1'b0;
`endif

  logic [INST_W-1:0] rom [16];
  int unsigned       exp_q [$];
  int                checks   = 0;
  int                failures = 0;

  fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  assign bus.rom_data = rom[bus.rom_addr];

  fetch_sequencer #(
    .ADDR_W       (ADDR_W),
    .INST_W       (INST_W),
    .RESET_PC     (4'd0),
    .HALT_ON_WRAP (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop_req    (stop_req),
`ifdef FETCH_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .bus         (bus.master),
    .busy        (busy),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back(a);
  endtask

  task automatic wait_addr(input logic [ADDR_W-1:0] a, input string tag);
    int n = 0;
    while (bus.rom_addr !== a && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check(tag, 32'(bus.rom_addr), 32'(a));
  endtask

  task automatic wait_halted(input string tag);
    int n = 0;
    while (halted !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check(tag, 32'(halted), 32'd1);
  endtask

  // Scoreboard: each handshake seen mid-cycle is taken at the next edge.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(bus.inst_pc), 32'hFFFF_FFFF);
      end else begin
        automatic int unsigned e = exp_q.pop_front();
        check("sb_inst_pc", 32'(bus.inst_pc), e);
        check("sb_inst", 32'(bus.inst), 32'(rom[e]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rom[0] = 16'h1E09;
    rom[1] = 16'h100A;
    for (int i = 2; i < 16; i++) rom[i] = 16'hC000 + 16'(i * 16'h0111);

    reset         = 1'b1;
    start         = 1'b0;
    stop_req      = 1'b0;
    bus.inst_ready = 1'b1;
    bus.br_valid  = 1'b0;
    bus.br_target = '0;

    // Reset state.
    tick();
    tick();
    check("rst_inst", 32'(bus.inst), 32'd0);
    check("rst_inst_pc", 32'(bus.inst_pc), 32'd0);
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);
    check("rst_addr", 32'(bus.rom_addr), 32'd0);
    reset = 1'b0;
    tick();

    // Free run, stall on 0x100A, then branch 5 -> 12 and halt on wrap.
    push_range(0, 4);
    push_range(12, 15);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy", 32'(busy), 32'd1);
    tick();
    tick();
    bus.inst_ready = 1'b0;
    check("fr_inst", 32'(bus.inst), 32'h100A);
    check("fr_inst_pc", 32'(bus.inst_pc), 32'd1);
    check("fr_count", 32'(fetch_count), 32'd2);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_inst", 32'(bus.inst), 32'h100A);
      check("stall_inst_pc", 32'(bus.inst_pc), 32'd1);
      check("stall_addr", 32'(bus.rom_addr), 32'd2);
    end
    bus.inst_ready = 1'b1;
    wait_addr(4'd5, "wait_pc5");
    bus.br_valid  = 1'b1;
    bus.br_target = 4'd12;
    tick();
    bus.br_valid = 1'b0;
    check("br_flush", 32'(bus.inst_valid), 32'd0);
    check("br_addr", 32'(bus.rom_addr), 32'd12);
    wait_halted("wait_halt_br");
    check("br_halt_pc", 32'(bus.inst_pc), 32'd15);
    check("br_count", 32'(fetch_count), 32'd9);
    check("br_wrap_addr", 32'(bus.rom_addr), 32'd0);
    check("br_busy", 32'(busy), 32'd0);
    tick();
    check("br_drained", 32'(bus.inst_valid), 32'd0);

    // Full wrap from 0: 16 fetches then halt.
    push_range(0, 15);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wrap_restart", 32'(halted), 32'd0);
    wait_halted("wait_halt_wrap");
    check("wrap_inst_pc", 32'(bus.inst_pc), 32'd15);
    check("wrap_count", 32'(fetch_count), 32'd16);
    tick();
    check("wrap_drained", 32'(bus.inst_valid), 32'd0);

    // Restart, hold the first instruction, stop while it is held.
    bus.inst_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rs_inst_pc", 32'(bus.inst_pc), 32'd0);
    check("rs_valid", 32'(bus.inst_valid), 32'd1);
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    check("stop_halted", 32'(halted), 32'd1);
    tick();
    tick();
    check("stop_held", 32'(bus.inst_valid), 32'd1);
    check("stop_held_pc", 32'(bus.inst_pc), 32'd0);
    exp_q.push_back(0);
    bus.inst_ready = 1'b1;
    tick();
    check("stop_drained", 32'(bus.inst_valid), 32'd0);
    for (int c = 0; c < 3; c++) tick();
    check("stop_no_fetch", 32'(fetch_count), 32'd1);
    check("stop_addr", 32'(bus.rom_addr), 32'd1);
    check("stop_still_empty", 32'(bus.inst_valid), 32'd0);

    // Asynchronous reset mid-run at pc = 7.
    push_range(0, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_addr(4'd7, "wait_pc7");
    reset = 1'b1;
    #1;
    check("ar_inst", 32'(bus.inst), 32'd0);
    check("ar_inst_pc", 32'(bus.inst_pc), 32'd0);
    check("ar_valid", 32'(bus.inst_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_halted", 32'(halted), 32'd0);
    check("ar_count", 32'(fetch_count), 32'd0);
    check("ar_addr", 32'(bus.rom_addr), 32'd0);
    tick();
    reset = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_target = 4'd9;
    tick();
    bus.br_valid = 1'b0;
    tick();
    check("idle_br_addr", 32'(bus.rom_addr), 32'd0);
    check("idle_br_busy", 32'(busy), 32'd0);
    check("idle_br_valid", 32'(bus.inst_valid), 32'd0);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 16-entry, 16-bit program ROM.
- Owns the program counter and drives the ROM address.
- Captures the combinational ROM output into a one-entry instruction register and hands it to decode with a valid/ready handshake.
- Handles start/stop, branch redirects from execute, and halting on PC wrap.

Parameters:
- ADDR_W, 4, PC / ROM address width (16 entries).
- INST_W, 16, instruction width.
- RESET_PC, 0, PC loaded on reset and on every start.
- HALT_ON_WRAP, 1, 1 = halt after the fetch at address 2^ADDR_W-1; 0 = wrap the PC to 0 and keep running.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begin fetching from RESET_PC.
- stop_req  in  1  pulse; stop fetching after the current held instruction.
- rom_addr  out  ADDR_W  address to the program ROM; always equals pc.
- rom_data  in  INST_W  combinational ROM output for rom_addr.
- inst  out  INST_W  held instruction.
- inst_pc  out  ADDR_W  address the held instruction was fetched from.
- inst_valid  out  1  held instruction is valid.
- inst_ready  in  1  decode accepts inst this cycle.
- br_valid  in  1  redirect request from execute.
- br_target  in  ADDR_W  redirect address.
- busy  out  1  high in RUN.
- halted  out  1  high in HALTED.
- fetch_count  out  8  fetches since the last start; saturates at 255.

Behaviour:
Reset:
- State = IDLE, pc = RESET_PC.
- inst = 0, inst_pc = 0, inst_valid = 0, busy = 0, halted = 0, fetch_count = 0.
- Reset asserted mid-run clears everything immediately, including a held instruction.

States and transitions:
- IDLE to RUN on start. Load pc = RESET_PC and clear fetch_count.
- RUN to HALTED on stop_req, or on a fetch at the last address when HALT_ON_WRAP = 1.
- HALTED to RUN on start, with the same loads as from IDLE.

Fetch slot:
- The slot is free when inst_valid = 0 or inst_ready = 1.
- In RUN with a free slot and no br_valid, one fetch per cycle:
  - inst <= rom_data, inst_pc <= pc, inst_valid <= 1.
  - pc <= pc + 1, modulo 2^ADDR_W.
  - fetch_count increments.
- Latency: an instruction is valid one cycle after its address is driven. Throughput is 1 instruction per cycle while inst_ready stays high.
- When the slot is not free (stall), inst, inst_pc and pc all hold.

Branch:
- br_valid in RUN has priority over fetch and over a stall.
- Effect: pc <= br_target and inst_valid <= 0 (flush). No fetch occurs that cycle.
- First fetch from the target happens the next cycle, so a taken branch costs 1 bubble.
- br_valid outside RUN is ignored.

Stop:
- stop_req and br_valid in the same cycle: the branch updates pc, then the block goes HALTED.
- On entering HALTED, a held instruction stays valid until accepted, then inst_valid clears. No new fetches occur.

Wrap:
- HALT_ON_WRAP = 1: the fetch at address 15 still completes, pc wraps to 0, state goes HALTED.
- HALT_ON_WRAP = 0: pc wraps silently and the block stays in RUN.

Other simultaneous events:
- start in RUN is ignored.
- start and stop_req together in IDLE or HALTED: start wins.

Optional Feature:
- Macro: FETCH_STEP_EN.
- When defined:
  - Adds inputs step_mode (1) and step (1).
  - With step_mode = 1, a RUN fetch additionally requires a step pulse. Exactly one fetch per pulse.
  - A pulse arriving while the slot is full is remembered (1-deep) and consumed at the next free slot.
  - Branch and stop behaviour are unchanged.
- When not defined: no such ports; fetch runs freely.

Decomposition:
- Shared package fetch_pkg holds:
  - State enum {IDLE, RUN, HALTED}.
  - ADDR_W and INST_W defaults.
  - Opcode field slice constants (inst[15:12]) and opcode values: NOP = 0000, LOAD = 0001, ADD = 0010, BR = 1100, MOV = 1110, OUT = 1111.
- One natural sub-module: pc_counter, holding load/increment/wrap and the wrap flag.
- Instruction register, handshake and FSM live in the top module.

Test Plan:
- Free run: ROM[0] = 0x1E09, ROM[1] = 0x100A, inst_ready = 1, pulse start → inst = 0x1E09 with inst_pc = 0 one cycle after start, then 0x100A with inst_pc = 1; fetch_count = 2.
- Stall: hold inst_ready = 0 for 3 cycles while inst = 0x100A → inst, inst_pc = 1 and rom_addr = 2 stay stable; after release, the next inst has inst_pc = 2.
- Branch: br_valid with br_target = 12 while pc = 5 → inst_valid = 0 next cycle, then inst_pc = 12; the instruction at 5 is never presented.
- Wrap/halt (HALT_ON_WRAP = 1): run from 0 → 16 instructions, halted = 1 after inst_pc = 15, fetch_count = 16; restart with start → inst_pc = 0.
- Stop with a held instruction: stop_req while inst_valid = 1 and inst_ready = 0 → HALTED, inst stays valid until inst_ready = 1, then inst_valid = 0 and no further fetches.
- Async reset mid-run at pc = 7 → all outputs zero immediately, state IDLE, pc = RESET_PC; br_valid in IDLE is ignored.
